// File: rtl/control_sequence_packer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequence_packer
// Brief    : Packs OSR CBADC control vectors per frame into {HI,LO} word
//            pairs, buffers them in a FIFO and serves them over PCPI.
// Revision : 1.0 - initial release
// ============================================================================
module control_sequence_packer #(
    parameter int N          = 8,
    parameter int OSR        = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        cs_valid,
    input  logic [N-1:0]                cs_bits,
    input  logic                        cs_restart,
    input  logic                        pcpi_valid,
    input  logic [31:0]                 pcpi_insn,
    input  logic [31:0]                 pcpi_rs1,
    output logic                        pcpi_wr,
    output logic [31:0]                 pcpi_rd,
    output logic                        pcpi_wait,
    output logic                        pcpi_ready,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int c_R2      = 32 / N;
    localparam int c_R1      = OSR - c_R2;
    localparam int c_SLOT_W  = $clog2(OSR);
    localparam int c_AW      = $clog2(FIFO_DEPTH);
    localparam int c_OSR_REQ = (N == 3) ? 20 : (N == 4) ? 15 : (N == 5) ? 12 :
                               (N == 6) ? 9  : (N == 7) ? 8  : (N == 8) ? 7  : 0;

    generate
        if (OSR != c_OSR_REQ) begin : g_bad_osr
            $error("OSR does not match the frame length required for N");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DECODE  = 3'd1,
        S_STALL   = 3'd2,
        S_RESPOND = 3'd3,
        S_GUARD   = 3'd4
    } state_t;

    state_t              r_state, w_state_next;
    logic [1:0]          r_sel, w_sel_next;
    logic [31:0]         r_rd, w_rd_next, w_rd_data;
    logic [c_SLOT_W-1:0] r_slot;
    logic [31:0]         r_lo, r_hi, w_lo_next, w_hi_next, w_vec;
    logic [4:0]          w_shamt;
    logic                w_last, w_push_req, w_push, w_pop, w_full, w_empty;
    logic                w_match, w_ovf_clr, r_overflow;
    logic [63:0]         r_mem [FIFO_DEPTH];
    logic [63:0]         w_head;
    logic [c_AW-1:0]     r_wptr, r_rptr;
    logic [c_AW:0]       r_level;
    logic                w_unused_ok;

    assign w_unused_ok = ^pcpi_rs1[31:2];

    // ---------------- frame packing ----------------
    assign w_vec      = 32'(cs_bits);
    assign w_last     = (int'(r_slot) == OSR - 1);
    assign w_push_req = cs_valid && !cs_restart && w_last;

    // Registers are cleared per frame, so OR-ing the new vector in is enough.
    always_comb begin
        w_lo_next = r_lo;
        w_hi_next = r_hi;
        if (int'(r_slot) < c_R1) begin
            w_shamt   = 5'(int'(r_slot) * N);
            w_lo_next = r_lo | (w_vec << w_shamt);
        end else begin
            w_shamt   = 5'((int'(r_slot) - c_R1) * N);
            w_hi_next = r_hi | (w_vec << w_shamt);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_slot <= '0;
            r_lo   <= '0;
            r_hi   <= '0;
        end else if (cs_restart || (cs_valid && w_last)) begin
            r_slot <= '0;
            r_lo   <= '0;
            r_hi   <= '0;
        end else if (cs_valid) begin
            r_slot <= r_slot + c_SLOT_W'(1);
            r_lo   <= w_lo_next;
            r_hi   <= w_hi_next;
        end
    end

    // ---------------- frame FIFO ----------------
    assign w_full    = (r_level == (c_AW + 1)'(FIFO_DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_pop     = (r_state == S_RESPOND) && (r_sel == 2'd1) && !w_empty;
    assign w_push    = w_push_req && (!w_full || w_pop);
    assign w_ovf_clr = (r_state == S_RESPOND) && (r_sel == 2'd2);
    assign w_head    = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_hi_next, w_lo_next};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_AW'(1);
            if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (c_AW + 1)'(1);
                2'b01:   r_level <= r_level - (c_AW + 1)'(1);
                default: r_level <= r_level;
            endcase
            // A dropped frame outranks a status-read clear in the same cycle.
            if (w_push_req && !w_push) r_overflow <= 1'b1;
            else if (w_ovf_clr)        r_overflow <= 1'b0;
        end
    end

    // ---------------- PCPI front end ----------------
    assign w_match = pcpi_valid && ((pcpi_insn & 32'hfe00707f) == 32'h00005027);

    always_comb begin
        case (r_sel)
            2'd0:    w_rd_data = w_head[31:0];
            2'd1:    w_rd_data = w_head[63:32];
            2'd2:    w_rd_data = {r_overflow, 15'b0, 16'(r_level)};
            default: w_rd_data = '0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_rd_next    = r_rd;
        case (r_state)
            S_IDLE: begin
                if (w_match) begin
                    w_state_next = S_DECODE;
                    w_sel_next   = pcpi_rs1[1:0];
                end
            end
            S_DECODE: begin
                if (!r_sel[1] && w_empty) begin
                    w_state_next = S_STALL;
                end else begin
                    w_rd_next    = w_rd_data;
                    w_state_next = S_RESPOND;
                end
            end
            S_STALL: begin
                if (!pcpi_valid) begin
                    w_state_next = S_IDLE;
                end else if (!w_empty) begin
                    w_rd_next    = w_rd_data;
                    w_state_next = S_RESPOND;
                end
            end
            S_RESPOND: w_state_next = S_GUARD;
            S_GUARD:   w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_rd    <= '0;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            r_rd    <= w_rd_next;
        end
    end

    assign pcpi_ready = (r_state == S_RESPOND);
    assign pcpi_wr    = (r_state == S_RESPOND);
    assign pcpi_wait  = (r_state == S_STALL);
    assign pcpi_rd    = (r_state == S_RESPOND) ? r_rd : '0;
    assign overflow   = r_overflow;
    assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_control_sequence_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_sequence_packer
// Brief    : Randomized and directed bench with a frame-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_sequence_packer;
    localparam int N = 8, OSR = 7, DEPTH = 4;

    logic        clk = 1'b0, resetn = 1'b0, tgt = 1'b0;
    logic        cs_valid = 1'b0, cs_restart = 1'b0, pcpi_valid = 1'b0;
    logic [7:0]  cs_bits = '0;
    logic [31:0] pcpi_insn = '0, pcpi_rs1 = '0;

    logic        cs_valid8, cs_valid3, pcpi_valid8, pcpi_valid3;
    logic        wr8, ready8, wait8, ovf8, wr3, ready3, wait3, ovf3;
    logic [31:0] rd8, rd3;
    logic [2:0]  lvl8, lvl3;
    logic        m_ready, m_wr, m_wait, m_ovf;
    logic [31:0] m_rd;
    logic [2:0]  m_level;

    assign cs_valid8   = cs_valid && !tgt;
    assign cs_valid3   = cs_valid && tgt;
    assign pcpi_valid8 = pcpi_valid && !tgt;
    assign pcpi_valid3 = pcpi_valid && tgt;
    assign m_ready = tgt ? ready3 : ready8;
    assign m_wr    = tgt ? wr3    : wr8;
    assign m_wait  = tgt ? wait3  : wait8;
    assign m_ovf   = tgt ? ovf3   : ovf8;
    assign m_rd    = tgt ? rd3    : rd8;
    assign m_level = tgt ? lvl3   : lvl8;

    control_sequence_packer #(.N(8), .OSR(7), .FIFO_DEPTH(4)) u_dut8 (
        .clk(clk), .resetn(resetn), .cs_valid(cs_valid8), .cs_bits(cs_bits),
        .cs_restart(cs_restart), .pcpi_valid(pcpi_valid8), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_wr(wr8), .pcpi_rd(rd8), .pcpi_wait(wait8),
        .pcpi_ready(ready8), .overflow(ovf8), .fifo_level(lvl8));

    control_sequence_packer #(.N(3), .OSR(20), .FIFO_DEPTH(4)) u_dut3 (
        .clk(clk), .resetn(resetn), .cs_valid(cs_valid3), .cs_bits(cs_bits[2:0]),
        .cs_restart(cs_restart), .pcpi_valid(pcpi_valid3), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_wr(wr3), .pcpi_rd(rd3), .pcpi_wait(wait3),
        .pcpi_ready(ready3), .overflow(ovf3), .fifo_level(lvl3));

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: completed frames in order, plus the vectors of the open frame.
    logic [63:0] mq[$];
    int          pv[$];
    bit          movf = 1'b0;

    function automatic logic [63:0] pack_frame(input int n, input int osr);
        logic [31:0] lo, hi;
        int r1;
        lo = '0;
        hi = '0;
        r1 = osr - 32 / n;
        for (int j = 0; j < osr; j++) begin
            if (j < r1) lo = lo | (32'(pv[j]) << (j * n));
            else        hi = hi | (32'(pv[j]) << ((j - r1) * n));
        end
        return {hi, lo};
    endfunction

    function automatic void model_strobe(input int v, input bit restart);
        logic [63:0] f;
        if (restart) begin
            pv.delete();
        end else begin
            pv.push_back(v);
            if (pv.size() == OSR) begin
                f = pack_frame(N, OSR);
                pv.delete();
                if (mq.size() < DEPTH) mq.push_back(f);
                else movf = 1'b1;
            end
        end
    endfunction

    function automatic logic [31:0] good_insn();
        return 32'h00005027 | ($urandom & ~32'hfe00707f);
    endfunction

    task automatic strobe(input logic [7:0] v, input bit restart);
        @(negedge clk);
        cs_valid = 1'b1;
        cs_bits = v;
        cs_restart = restart;
        @(negedge clk);
        cs_valid = 1'b0;
        cs_restart = 1'b0;
        if (!tgt) model_strobe(int'(v), restart);
    endtask

    task automatic start_read(input logic [1:0] sel);
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn = good_insn();
        pcpi_rs1 = {30'($urandom), sel};
    endtask

    // Holds pcpi_valid through the guard cycle to show the request is not re-issued.
    task automatic finish_read(input int max_cyc, output logic [31:0] data, output int lat);
        lat = 0;
        data = '0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_ready && lat < max_cyc);
        if (!m_ready) begin
            chk("ready_timeout", 64'(m_ready), 64'd1);
            pcpi_valid = 1'b0;
            return;
        end
        data = m_rd;
        chk("wr_with_ready", 64'(m_wr), 64'd1);
        @(negedge clk);
        chk("guard_quiet", {m_ready, m_wr, m_wait, |m_rd}, 64'd0);
        pcpi_valid = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] sel);
        logic [31:0] exp_rd, got;
        logic [63:0] head;
        int lat;
        head = (mq.size() != 0) ? mq[0] : 64'd0;
        case (sel)
            2'd0:    exp_rd = head[31:0];
            2'd1:    exp_rd = head[63:32];
            2'd2:    exp_rd = {movf, 15'b0, 16'(mq.size())};
            default: exp_rd = '0;
        endcase
        start_read(sel);
        finish_read(8, got, lat);
        chk($sformatf("rd_sel%0d", sel), 64'(got), 64'(exp_rd));
        chk("latency", 64'(lat), 64'd2);
        if (sel == 2'd1 && mq.size() != 0) void'(mq.pop_front());
        if (sel == 2'd2) movf = 1'b0;
        chk("level", 64'(m_level), 64'(mq.size()));
        chk("overflow", 64'(m_ovf), 64'(movf));
    endtask

    task automatic bad_req();
        logic [31:0] msk;
        int b;
        bit busy;
        msk = 32'hfe00707f;
        busy = 1'b0;
        do b = $urandom_range(0, 31); while (!msk[b]);
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn = good_insn() ^ (32'd1 << b);
        pcpi_rs1 = $urandom;
        repeat (4) begin
            @(negedge clk);
            if (m_ready || m_wait || m_wr) busy = 1'b1;
        end
        chk("nomatch_quiet", 64'(busy), 64'd0);
        pcpi_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        mq.delete();
        pv.delete();
        movf = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        logic [31:0] got, exp_hi;
        logic [63:0] f6;
        logic [7:0]  v7;
        logic [1:0]  s;
        int          lat, op, k;

        repeat (2) @(negedge clk);
        chk("reset_outs8", {wr8, ready8, wait8, ovf8, lvl8, rd8}, 64'd0);
        chk("reset_outs3", {wr3, ready3, wait3, ovf3, lvl3, rd3}, 64'd0);
        resetn = 1'b1;

        // Basic frame 0x01..0x07
        for (int v = 1; v <= 6; v++) strobe(8'(v), 1'b0);
        chk("t1_level_partial", 64'(m_level), 64'd0);
        strobe(8'h07, 1'b0);
        chk("t1_level", 64'(m_level), 64'd1);
        start_read(2'd0);
        finish_read(8, got, lat);
        chk("t1_lo", 64'(got), 64'h00030201);
        chk("t1_latency", 64'(lat), 64'd2);
        start_read(2'd1);
        finish_read(8, got, lat);
        chk("t1_hi", 64'(got), 64'h07060504);
        void'(mq.pop_front());
        chk("t1_level_popped", 64'(m_level), 64'd0);

        // Read on empty FIFO stalls until a frame arrives
        start_read(2'd1);
        repeat (3) @(negedge clk);
        chk("t2_wait", 64'(m_wait), 64'd1);
        chk("t2_no_ready", 64'(m_ready), 64'd0);
        for (int v = 0; v < 7; v++) strobe(8'($urandom), 1'b0);
        exp_hi = mq[0][63:32];
        finish_read(10, got, lat);
        chk("t2_hi", 64'(got), 64'(exp_hi));
        void'(mq.pop_front());
        chk("t2_level", 64'(m_level), 64'd0);

        // Stall abandoned when pcpi_valid drops
        start_read(2'd0);
        repeat (3) @(negedge clk);
        chk("abort_wait", 64'(m_wait), 64'd1);
        pcpi_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_quiet", {m_wait, m_ready}, 64'd0);

        bad_req();

        // Overflow: five frames into a four-deep FIFO
        for (int v = 0; v < 35; v++) strobe(8'($urandom), 1'b0);
        chk("t3_level", 64'(m_level), 64'd4);
        chk("t3_overflow", 64'(m_ovf), 64'd1);
        repeat (4) begin
            do_read(2'd0);
            do_read(2'd1);
        end
        do_read(2'd2);

        // Push lands in the same cycle as a pop on a full FIFO
        for (int v = 0; v < 34; v++) strobe(8'($urandom), 1'b0);
        chk("t4_full", 64'(m_level), 64'd4);
        v7 = 8'($urandom);
        exp_hi = mq[0][63:32];
        start_read(2'd1);
        repeat (2) @(negedge clk);
        chk("t4_ready", 64'(m_ready), 64'd1);
        got = m_rd;
        cs_valid = 1'b1;
        cs_bits = v7;
        @(negedge clk);
        cs_valid = 1'b0;
        pcpi_valid = 1'b0;
        chk("t4_hi", 64'(got), 64'(exp_hi));
        void'(mq.pop_front());
        model_strobe(int'(v7), 1'b0);
        chk("t4_level", 64'(m_level), 64'd4);
        chk("t4_overflow", 64'(m_ovf), 64'd0);
        repeat (4) begin
            do_read(2'd0);
            do_read(2'd1);
        end

        // Restart discards the partial frame
        for (int v = 0; v < 3; v++) strobe(8'($urandom), 1'b0);
        strobe(8'($urandom), 1'b1);
        for (int v = 8'h11; v <= 8'h17; v++) strobe(8'(v), 1'b0);
        start_read(2'd0);
        finish_read(8, got, lat);
        chk("t5_lo", 64'(got), 64'h00131211);
        start_read(2'd1);
        finish_read(8, got, lat);
        chk("t5_hi", 64'(got), 64'h17161514);
        void'(mq.pop_front());
        chk("t5_level", 64'(m_level), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 5) begin
                strobe(8'($urandom), ($urandom_range(0, 15) == 0));
                chk("rnd_level", 64'(m_level), 64'(mq.size()));
                chk("rnd_overflow", 64'(m_ovf), 64'(movf));
            end else if (op <= 8) begin
                k = $urandom_range(0, 5);
                s = (k == 0) ? 2'd0 : (k <= 3) ? 2'd1 : (k == 4) ? 2'd2 : 2'd3;
                if (!s[1] && mq.size() == 0) s = 2'd2;
                do_read(s);
            end else begin
                bad_req();
            end
        end

        // N=3, OSR=20 instance
        do_reset();
        tgt = 1'b1;
        for (int j = 0; j < 20; j++) strobe(8'(j % 8), 1'b0);
        chk("t6_level", 64'(m_level), 64'd1);
        pv.delete();
        for (int j = 0; j < 20; j++) pv.push_back(j % 8);
        f6 = pack_frame(3, 20);
        pv.delete();
        start_read(2'd0);
        finish_read(8, got, lat);
        chk("t6_lo", 64'(got), 64'(f6[31:0]));
        chk("t6_lo_top", 64'(got[31:30]), 64'd0);
        start_read(2'd1);
        finish_read(8, got, lat);
        chk("t6_hi", 64'(got), 64'(f6[63:32]));
        chk("t6_level_popped", 64'(m_level), 64'd0);
        for (int j = 0; j < 25; j++) strobe(8'($urandom), 1'b0);
        chk("t6_level_pre_reset", 64'(m_level), 64'd1);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1 chk("t6_async_reset", {m_level, m_ovf}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int j = 0; j < 15; j++) strobe(8'($urandom), 1'b0);
        chk("t6_no_stale_push", 64'(m_level), 64'd0);
        tgt = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
